// File: rtl/adc_accum.sv
// adc_accum: dual-channel ADC sample accumulator.
// Sums 2^SAMPLES_LOG2 signed samples per channel, flags every period of
// 2^PERIOD_LOG2 samples, and holds the scaled result until it is consumed.
module adc_accum #(
  parameter int CH_WIDTH     = 18,
  parameter int SAMPLES_LOG2 = 10,
  parameter int OUT_WIDTH    = 24,
  parameter int PERIOD_LOG2  = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    sample_valid,
  input  logic [2*CH_WIDTH-1:0]   sample_data,
  input  logic                    out_ready,
  output logic                    out_valid,
  output logic [OUT_WIDTH-1:0]    data_out_1,
  output logic [OUT_WIDTH-1:0]    data_out_2,
  output logic                    period_done,
  output logic                    busy,
  output logic                    overrun
);

  // Accumulator width is chosen so a full run of extreme samples cannot overflow.
  localparam int ACC_WIDTH = CH_WIDTH + SAMPLES_LOG2;
  // The output is the top OUT_WIDTH bits of the final accumulator.
  localparam int SHIFT     = SAMPLES_LOG2 - (OUT_WIDTH - CH_WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic signed [ACC_WIDTH-1:0] acc_1;
  logic signed [ACC_WIDTH-1:0] acc_2;
  logic signed [ACC_WIDTH-1:0] sum_1;
  logic signed [ACC_WIDTH-1:0] sum_2;
  logic [SAMPLES_LOG2-1:0]     count;
  logic [CH_WIDTH-1:0]         ch_1;
  logic [CH_WIDTH-1:0]         ch_2;

  logic acc_clear;
  logic accept;
  logic last_sample;
  logic period_wrap;
  logic clear_overrun;
  logic set_overrun;

  assign ch_1 = sample_data[2*CH_WIDTH-1:CH_WIDTH];
  assign ch_2 = sample_data[CH_WIDTH-1:0];

  // Sign-extend each channel and form the running sums including this sample,
  // so the final result already contains the last accepted sample.
  assign sum_1 = acc_1 + {{SAMPLES_LOG2{ch_1[CH_WIDTH-1]}}, ch_1};
  assign sum_2 = acc_2 + {{SAMPLES_LOG2{ch_2[CH_WIDTH-1]}}, ch_2};

  // The counter sits at all-ones on the last sample of a run or of a period.
  assign last_sample = &count;
  assign period_wrap = &count[PERIOD_LOG2-1:0];

  assign busy      = (state == ACCUM);
  assign out_valid = (state == HOLD);

  // State register; reset returns to IDLE and drops any pending result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and datapath control decode.
  always_comb begin
    state_next    = state;
    acc_clear     = 1'b0;
    accept        = 1'b0;
    clear_overrun = 1'b0;
    set_overrun   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          acc_clear     = 1'b1;
          clear_overrun = 1'b1;
          state_next    = ACCUM;
        end
      end
      ACCUM: begin
        if (start) begin
          acc_clear = 1'b1;
        end else if (sample_valid) begin
          accept = 1'b1;
          if (last_sample) begin
            state_next = HOLD;
          end
        end
      end
      HOLD: begin
        if (sample_valid) begin
          set_overrun = 1'b1;
        end
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Accumulators and sample counter; start wins over a same-cycle sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_1 <= '0;
      acc_2 <= '0;
      count <= '0;
    end else if (acc_clear) begin
      acc_1 <= '0;
      acc_2 <= '0;
      count <= '0;
    end else if (accept) begin
      acc_1 <= sum_1;
      acc_2 <= sum_2;
      count <= count + 1'b1;
    end
  end

  // Result registers capture the scaled sums only when entering HOLD.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out_1 <= '0;
      data_out_2 <= '0;
    end else if (accept && last_sample) begin
      data_out_1 <= sum_1[ACC_WIDTH-1:SHIFT];
      data_out_2 <= sum_2[ACC_WIDTH-1:SHIFT];
    end
  end

  // Period pulse follows the sample that completes each period.
  always_ff @(posedge clk) begin
    if (rst) begin
      period_done <= 1'b0;
    end else begin
      period_done <= accept && period_wrap;
    end
  end

  // Sticky overrun: set by samples arriving while a result is pending.
  always_ff @(posedge clk) begin
    if (rst) begin
      overrun <= 1'b0;
    end else if (clear_overrun) begin
      overrun <= 1'b0;
    end else if (set_overrun) begin
      overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_adc_accum.sv
// tb_adc_accum: self-checking bench for adc_accum with a cycle-level
// reference model, a table of full-run vectors and hand-written corner cases.
module tb_adc_accum;

  localparam int CHW   = 18;
  localparam int SL2   = 10;
  localparam int OUTW  = 24;
  localparam int PL2   = 5;
  localparam int NSAMP = 1 << SL2;
  localparam int NPER  = 1 << PL2;
  localparam int SHIFT = SL2 - (OUTW - CHW);

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              sample_valid = 1'b0;
  logic [2*CHW-1:0]  sample_data = '0;
  logic              out_ready = 1'b0;
  logic              out_valid;
  logic [OUTW-1:0]   data_out_1;
  logic [OUTW-1:0]   data_out_2;
  logic              period_done;
  logic              busy;
  logic              overrun;

  int vectors    = 0;
  int miscompares = 0;
  bit chk_en     = 1'b0;
  bit ready_lvl  = 1'b1;
  int pd_count   = 0;
  int ov_count   = 0;

  adc_accum #(
    .CH_WIDTH(CHW), .SAMPLES_LOG2(SL2), .OUT_WIDTH(OUTW), .PERIOD_LOG2(PL2)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .sample_valid(sample_valid),
    .sample_data(sample_data), .out_ready(out_ready), .out_valid(out_valid),
    .data_out_1(data_out_1), .data_out_2(data_out_2),
    .period_done(period_done), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Compare one observed value against the bench's expectation.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one clock cycle of inputs; pulses are dropped again afterwards.
  task automatic applyStimulus(input bit st, input bit sv, input int d1, input int d2);
    logic [CHW-1:0] a;
    logic [CHW-1:0] b;
    a = d1[CHW-1:0];
    b = d2[CHW-1:0];
    start        = st;
    sample_valid = sv;
    sample_data  = {a, b};
    out_ready    = ready_lvl;
    @(posedge clk);
    #1;
    start        = 1'b0;
    sample_valid = 1'b0;
  endtask

  // Feed n samples of constant value with gap idle cycles after each.
  task automatic feedSamples(input int n, input int d1, input int d2, input int gap);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, 1'b1, d1, d2);
      for (int g = 0; g < gap; g++) applyStimulus(1'b0, 1'b0, 0, 0);
    end
  endtask

  // Reference model: tracks whether a run is active or a result pending,
  // the plain integer sums of accepted samples and how many were taken.
  bit             m_active = 1'b0;
  bit             m_pending = 1'b0;
  bit             m_overrun = 1'b0;
  bit             m_pd = 1'b0;
  longint         m_sum1 = 0;
  longint         m_sum2 = 0;
  int             m_n = 0;
  logic [OUTW-1:0] m_o1 = '0;
  logic [OUTW-1:0] m_o2 = '0;
  logic signed [CHW-1:0] m_s1;
  logic signed [CHW-1:0] m_s2;

  // Advance the model on every rising edge from the inputs the bench drove.
  always @(posedge clk) begin
    m_s1 = sample_data[2*CHW-1:CHW];
    m_s2 = sample_data[CHW-1:0];
    m_pd = 1'b0;
    if (rst) begin
      m_active = 0; m_pending = 0; m_overrun = 0;
      m_sum1 = 0; m_sum2 = 0; m_n = 0; m_o1 = '0; m_o2 = '0;
    end else if (m_pending) begin
      if (sample_valid) m_overrun = 1;
      if (out_ready) m_pending = 0;
    end else if (m_active) begin
      if (start) begin
        m_sum1 = 0; m_sum2 = 0; m_n = 0;
      end else if (sample_valid) begin
        m_sum1 += m_s1;
        m_sum2 += m_s2;
        m_n++;
        if (m_n % NPER == 0) m_pd = 1;
        if (m_n == NSAMP) begin
          m_o1 = OUTW'(m_sum1 >>> SHIFT);
          m_o2 = OUTW'(m_sum2 >>> SHIFT);
          m_active = 0;
          m_pending = 1;
        end
      end
    end else if (start) begin
      m_active = 1; m_overrun = 0;
      m_sum1 = 0; m_sum2 = 0; m_n = 0;
    end
  end

  // Every falling edge, compare all DUT outputs with the model and tally pulses.
  always @(negedge clk) begin
    if (chk_en) begin
      checkOutput("out_valid", 32'(out_valid), 32'(m_pending));
      checkOutput("busy", 32'(busy), 32'(m_active));
      checkOutput("overrun", 32'(overrun), 32'(m_overrun));
      checkOutput("period_done", 32'(period_done), 32'(m_pd));
      checkOutput("data_out_1", 32'(data_out_1), 32'(m_o1));
      checkOutput("data_out_2", 32'(data_out_2), 32'(m_o2));
      if (period_done) pd_count++;
      if (out_valid) ov_count++;
    end
  end

  typedef struct {
    int ch1;
    int ch2;
    int gap;
    logic [OUTW-1:0] exp1;
    logic [OUTW-1:0] exp2;
  } vec_t;

  vec_t vecs[7];

  // Main test sequence.
  initial begin
    int pd_base;
    int ov_base;
    vecs[0] = '{1, -1, 0, 24'h000040, 24'hFFFFC0};
    vecs[1] = '{131071, -131072, 0, 24'h7FFFC0, 24'h800000};
    vecs[2] = '{2, 0, 0, 24'h000080, 24'h000000};
    vecs[3] = '{1, -1, 6, 24'h000040, 24'hFFFFC0};
    vecs[4] = '{-1, 0, 0, 24'hFFFFC0, 24'h000000};
    vecs[5] = '{3, -3, 1, 24'h0000C0, 24'hFFFF40};
    vecs[6] = '{17, -131072, 0, 24'h000440, 24'h800000};

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_en = 1'b1;
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_data_out_1", 32'(data_out_1), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);

    // Full accumulation runs from the table.
    ready_lvl = 1'b1;
    for (int v = 0; v < 7; v++) begin
      pd_base = pd_count;
      applyStimulus(1'b1, 1'b0, 0, 0);
      checkOutput("tbl_busy", 32'(busy), 32'd1);
      feedSamples(NSAMP - 1, vecs[v].ch1, vecs[v].ch2, vecs[v].gap);
      applyStimulus(1'b0, 1'b1, vecs[v].ch1, vecs[v].ch2);
      checkOutput("tbl_latency_valid", 32'(out_valid), 32'd1);
      checkOutput("tbl_data_1", 32'(data_out_1), 32'(vecs[v].exp1));
      checkOutput("tbl_data_2", 32'(data_out_2), 32'(vecs[v].exp2));
      applyStimulus(1'b0, 1'b0, 0, 0);
      checkOutput("tbl_back_idle", 32'(out_valid), 32'd0);
      checkOutput("tbl_period_pulses", 32'(pd_count - pd_base), 32'(NPER));
    end

    // Backpressure in HOLD with overrun strobes, then release and restart.
    ready_lvl = 1'b0;
    applyStimulus(1'b1, 1'b0, 0, 0);
    feedSamples(NSAMP, 3, -3, 0);
    checkOutput("hold_valid", 32'(out_valid), 32'd1);
    for (int k = 0; k < 10; k++) begin
      applyStimulus(1'b1, (k == 2 || k == 5 || k == 8), 7, 7);
      checkOutput("hold_data_1", 32'(data_out_1), 32'h0000C0);
      checkOutput("hold_data_2", 32'(data_out_2), 32'hFFFF40);
      checkOutput("hold_valid_stable", 32'(out_valid), 32'd1);
    end
    checkOutput("hold_overrun", 32'(overrun), 32'd1);
    ready_lvl = 1'b1;
    applyStimulus(1'b0, 1'b0, 0, 0);
    checkOutput("release_idle", 32'(out_valid), 32'd0);
    checkOutput("overrun_sticky", 32'(overrun), 32'd1);
    applyStimulus(1'b1, 1'b0, 0, 0);
    checkOutput("start_clears_overrun", 32'(overrun), 32'd0);

    // Abort after 500 samples; the aborting start also carries a sample.
    feedSamples(500, 5, 0, 0);
    applyStimulus(1'b1, 1'b1, 100, 100);
    checkOutput("abort_busy", 32'(busy), 32'd1);
    feedSamples(NSAMP - 1, 2, 0, 0);
    applyStimulus(1'b0, 1'b1, 2, 0);
    checkOutput("abort_valid", 32'(out_valid), 32'd1);
    checkOutput("abort_data_1", 32'(data_out_1), 32'h000080);
    applyStimulus(1'b0, 1'b0, 0, 0);
    checkOutput("idle_hold_data_1", 32'(data_out_1), 32'h000080);

    // Reset mid-run, then samples without a start must not produce a result.
    applyStimulus(1'b1, 1'b0, 0, 0);
    feedSamples(700, 9, -9, 0);
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 0, 0);
    rst = 1'b0;
    checkOutput("rst_data_1", 32'(data_out_1), 32'd0);
    checkOutput("rst_data_2", 32'(data_out_2), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_period_done", 32'(period_done), 32'd0);
    ov_base = ov_count;
    feedSamples(NSAMP, 1, 1, 0);
    checkOutput("no_start_no_valid", 32'(ov_count - ov_base), 32'd0);

    // Randomised traffic checked cycle by cycle against the model.
    for (int r = 0; r < 3; r++) begin
      ready_lvl = 1'b1;
      applyStimulus(1'b1, 1'b0, 0, 0);
      for (int c = 0; c < 3000; c++) begin
        ready_lvl = ($urandom_range(0, 3) == 0);
        rst = ($urandom_range(0, 4999) == 0);
        applyStimulus(($urandom_range(0, 3999) == 0), ($urandom_range(0, 3) != 0),
                      int'($urandom), int'($urandom));
        rst = 1'b0;
      end
    end

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
